// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the data memory: CPU has priority with zero added latency, DBG is granted when CPU idles or after STARVE_LIMIT starved cycles;
// DBG reads respond two cycles after dbg_ready, a granted DBG stalls the CPU for one cycle. Optional DBG bursts: DMEM_ARB_BURST_EN.
module dmem_arbiter #(
   parameter int ADDR_WID     = 16,
   parameter int DATA_WID     = 8,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_WID      = 3
`ifdef DMEM_ARB_BURST_EN
   ,
   parameter int BURST_MAX    = 4
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cpu_rd_req,
   input  logic                cpu_wr_req,
   input  logic [ADDR_WID-1:0] cpu_addr,
   input  logic [DATA_WID-1:0] cpu_wr_data,
   output logic                cpu_stall,
   output logic [DATA_WID-1:0] cpu_rd_data,
   input  logic                dbg_valid,
   input  logic                dbg_we,
   input  logic [ADDR_WID-1:0] dbg_addr,
   input  logic [DATA_WID-1:0] dbg_wr_data,
`ifdef DMEM_ARB_BURST_EN
   input  logic                dbg_burst,
`endif
   output logic                dbg_ready,
   output logic                dbg_rsp_valid,
   output logic [DATA_WID-1:0] dbg_rsp_data,
   output logic [ADDR_WID-1:0] dmem_rd_addr,
   output logic [ADDR_WID-1:0] dmem_wr_addr,
   output logic [DATA_WID-1:0] dmem_wr_data,
   output logic                dmem_wr_en,
   input  logic [DATA_WID-1:0] dmem_dout,
   output logic                grant_dbg
);

   typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} owner_t;

   localparam logic [CNT_WID-1:0] LP_STARVE_MAX = CNT_WID'(STARVE_LIMIT);

   owner_t              r_owner, w_owner_nxt;
   logic [CNT_WID-1:0]  r_starve_cnt, w_starve_nxt;
   logic                r_rd_pend;
   logic                r_rsp_valid;
   logic [DATA_WID-1:0] r_rsp_data;
   logic                w_cpu_req;
   logic                w_dbg_rd_acc;

`ifdef DMEM_ARB_BURST_EN
   localparam int BEAT_WID = $clog2(BURST_MAX + 1);
   localparam logic [BEAT_WID-1:0] LP_LAST_BEAT = BEAT_WID'(BURST_MAX - 1);
   logic [BEAT_WID-1:0] r_beat, w_beat_nxt;
`endif

   assign w_cpu_req     = cpu_rd_req | cpu_wr_req;
   assign w_dbg_rd_acc  = (r_owner == OWN_DBG) & dbg_valid & ~dbg_we;
   assign cpu_rd_data   = dmem_dout;
   assign dbg_rsp_valid = r_rsp_valid;
   assign dbg_rsp_data  = r_rsp_data;
   assign grant_dbg     = (r_owner == OWN_DBG);

   always_comb begin
      w_owner_nxt  = OWN_CPU;
      w_starve_nxt = r_starve_cnt;
      dmem_rd_addr = cpu_addr;
      dmem_wr_addr = cpu_addr;
      dmem_wr_data = cpu_wr_data;
      dmem_wr_en   = cpu_wr_req;
      cpu_stall    = 1'b0;
      dbg_ready    = 1'b0;
`ifdef DMEM_ARB_BURST_EN
      w_beat_nxt   = '0;
`endif
      if (r_owner == OWN_CPU) begin
         if (dbg_valid && w_cpu_req && (r_starve_cnt != LP_STARVE_MAX))
            w_starve_nxt = r_starve_cnt + 1'b1;
         if (dbg_valid && (!w_cpu_req || (r_starve_cnt == LP_STARVE_MAX)))
            w_owner_nxt = OWN_DBG;
      end else begin
         dmem_rd_addr = dbg_addr;
         dmem_wr_addr = dbg_addr;
         dmem_wr_data = dbg_wr_data;
         dmem_wr_en   = dbg_valid & dbg_we;
         dbg_ready    = dbg_valid;
         cpu_stall    = w_cpu_req;
         w_starve_nxt = '0;
`ifdef DMEM_ARB_BURST_EN
         // A full burst yields to a waiting CPU; an idle CPU lets DBG start another.
         if (dbg_valid && dbg_burst) begin
            if (r_beat != LP_LAST_BEAT) begin
               w_owner_nxt = OWN_DBG;
               w_beat_nxt  = r_beat + 1'b1;
            end else if (!w_cpu_req) begin
               w_owner_nxt = OWN_DBG;
            end
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_owner      <= OWN_CPU;
         r_starve_cnt <= '0;
         r_rd_pend    <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
`ifdef DMEM_ARB_BURST_EN
         r_beat       <= '0;
`endif
      end else begin
         r_owner      <= w_owner_nxt;
         r_starve_cnt <= w_starve_nxt;
         // Memory read data arrives one cycle after the accepted read.
         r_rd_pend    <= w_dbg_rd_acc;
         r_rsp_valid  <= r_rd_pend;
         if (r_rd_pend)
            r_rsp_data <= dmem_dout;
`ifdef DMEM_ARB_BURST_EN
         r_beat       <= w_beat_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read memory model.
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_rd_req, cpu_wr_req;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wr_data;
   logic        cpu_stall;
   logic [7:0]  cpu_rd_data;
   logic        dbg_valid, dbg_we;
   logic [15:0] dbg_addr;
   logic [7:0]  dbg_wr_data;
   logic        dbg_ready, dbg_rsp_valid;
   logic [7:0]  dbg_rsp_data;
   logic [15:0] dmem_rd_addr, dmem_wr_addr;
   logic [7:0]  dmem_wr_data;
   logic        dmem_wr_en;
   logic [7:0]  dmem_dout;
   logic        grant_dbg;

   logic [7:0]  mem [0:255] = '{default: 8'h00};
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dmem_wr_en) mem[dmem_wr_addr[7:0]] <= dmem_wr_data;
      dmem_dout <= mem[dmem_rd_addr[7:0]];
   end

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req), .cpu_addr(cpu_addr),
      .cpu_wr_data(cpu_wr_data), .cpu_stall(cpu_stall), .cpu_rd_data(cpu_rd_data),
      .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wr_data(dbg_wr_data),
      .dbg_ready(dbg_ready), .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data),
      .dmem_rd_addr(dmem_rd_addr), .dmem_wr_addr(dmem_wr_addr), .dmem_wr_data(dmem_wr_data),
      .dmem_wr_en(dmem_wr_en), .dmem_dout(dmem_dout), .grant_dbg(grant_dbg)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cpu_rd_req = 1'b0; cpu_wr_req = 1'b1; cpu_addr = 16'h1234; cpu_wr_data = 8'h5A;
      dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0000; dbg_wr_data = 8'h00;
      #2;
      n_vec++; if (grant_dbg !== 1'b0) begin n_err++; $display("FAIL rst_grant got %b exp 0", grant_dbg); end
      n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", cpu_stall); end
      n_vec++; if (dbg_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b exp 0", dbg_ready); end
      n_vec++; if (dbg_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b exp 0", dbg_rsp_valid); end
      n_vec++; if (dbg_rsp_data !== 8'h00) begin n_err++; $display("FAIL rst_rsp_data got %h exp 00", dbg_rsp_data); end
      n_vec++; if (dmem_wr_addr !== 16'h1234) begin n_err++; $display("FAIL rst_wr_addr got %h exp 1234", dmem_wr_addr); end
      n_vec++; if (dmem_wr_en !== 1'b1) begin n_err++; $display("FAIL rst_wr_en got %b exp 1", dmem_wr_en); end
      n_vec++; if (dmem_wr_data !== 8'h5A) begin n_err++; $display("FAIL rst_wr_data got %h exp 5a", dmem_wr_data); end
      cpu_wr_req = 1'b0; dbg_valid = 1'b0;
      cyc(); cyc();
      reset = 1'b1;
      cyc();
   endtask

   task automatic test_dbg_rw();
      dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0010; dbg_wr_data = 8'h3C;
      #1;
      n_vec++; if (dbg_ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_req got %b exp 0", dbg_ready); end
      cyc();
      n_vec++; if (dbg_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_acc got %b exp 1", dbg_ready); end
      n_vec++; if (dmem_wr_en !== 1'b1) begin n_err++; $display("FAIL wr_en_dbg got %b exp 1", dmem_wr_en); end
      n_vec++; if (dmem_wr_addr !== 16'h0010) begin n_err++; $display("FAIL wr_addr_dbg got %h exp 0010", dmem_wr_addr); end
      n_vec++; if (dmem_wr_data !== 8'h3C) begin n_err++; $display("FAIL wr_data_dbg got %h exp 3c", dmem_wr_data); end
      cyc();
      n_vec++; if (mem[8'h10] !== 8'h3C) begin n_err++; $display("FAIL wr_landed got %h exp 3c", mem[8'h10]); end
      dbg_we = 1'b0;
      #1;
      n_vec++; if (dbg_ready !== 1'b0) begin n_err++; $display("FAIL rd_ready_req got %b exp 0", dbg_ready); end
      cyc();
      n_vec++; if (dbg_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready_acc got %b exp 1", dbg_ready); end
      n_vec++; if (dmem_rd_addr !== 16'h0010) begin n_err++; $display("FAIL rd_addr got %h exp 0010", dmem_rd_addr); end
      n_vec++; if (dmem_wr_en !== 1'b0) begin n_err++; $display("FAIL rd_wr_en got %b exp 0", dmem_wr_en); end
      cyc();
      dbg_valid = 1'b0;
      #1;
      n_vec++; if (dbg_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rsp_t1 got %b exp 0", dbg_rsp_valid); end
      cyc();
      n_vec++; if (dbg_rsp_valid !== 1'b1) begin n_err++; $display("FAIL rsp_t2 got %b exp 1", dbg_rsp_valid); end
      n_vec++; if (dbg_rsp_data !== 8'h3C) begin n_err++; $display("FAIL rsp_data got %h exp 3c", dbg_rsp_data); end
      cyc();
      n_vec++; if (dbg_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rsp_t3 got %b exp 0", dbg_rsp_valid); end
      n_vec++; if (dbg_rsp_data !== 8'h3C) begin n_err++; $display("FAIL rsp_hold got %h exp 3c", dbg_rsp_data); end
   endtask

   task automatic test_starve();
      cpu_wr_req = 1'b1; cpu_addr = 16'h0030; cpu_wr_data = 8'h11;
      dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0040; dbg_wr_data = 8'h77;
      #1;
      for (int i = 0; i < 5; i++) begin
         n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL starve_stall_c%0d got %b exp 0", i + 1, cpu_stall); end
         n_vec++; if (dbg_ready !== 1'b0) begin n_err++; $display("FAIL starve_ready_c%0d got %b exp 0", i + 1, dbg_ready); end
         cyc();
      end
      n_vec++; if (dbg_ready !== 1'b1) begin n_err++; $display("FAIL starve_ready_c6 got %b exp 1", dbg_ready); end
      n_vec++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL starve_stall_c6 got %b exp 1", cpu_stall); end
      n_vec++; if (dmem_wr_addr !== 16'h0040) begin n_err++; $display("FAIL starve_addr_c6 got %h exp 0040", dmem_wr_addr); end
      cyc();
      dbg_valid = 1'b0;
      #1;
      n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL starve_stall_c7 got %b exp 0", cpu_stall); end
      n_vec++; if (grant_dbg !== 1'b0) begin n_err++; $display("FAIL starve_grant_c7 got %b exp 0", grant_dbg); end
      n_vec++; if (dmem_wr_addr !== 16'h0030) begin n_err++; $display("FAIL starve_addr_c7 got %h exp 0030", dmem_wr_addr); end
      cyc();
      cpu_wr_req = 1'b0;
      n_vec++; if (mem[8'h40] !== 8'h77) begin n_err++; $display("FAIL starve_dbg_mem got %h exp 77", mem[8'h40]); end
      n_vec++; if (mem[8'h30] !== 8'h11) begin n_err++; $display("FAIL starve_cpu_mem got %h exp 11", mem[8'h30]); end
   endtask

   task automatic test_cpu_store_stalled();
      dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0050; dbg_wr_data = 8'h99;
      cyc();
      cpu_wr_req = 1'b1; cpu_addr = 16'h0020; cpu_wr_data = 8'hA5;
      #1;
      n_vec++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL st_stall got %b exp 1", cpu_stall); end
      n_vec++; if (dmem_wr_data !== 8'h99) begin n_err++; $display("FAIL st_dbg_data got %h exp 99", dmem_wr_data); end
      cyc();
      dbg_valid = 1'b0;
      #1;
      n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL st_release got %b exp 0", cpu_stall); end
      n_vec++; if (dmem_wr_data !== 8'hA5) begin n_err++; $display("FAIL st_cpu_data got %h exp a5", dmem_wr_data); end
      cyc();
      cpu_wr_req = 1'b0; cpu_rd_req = 1'b1;
      n_vec++; if (mem[8'h20] !== 8'hA5) begin n_err++; $display("FAIL st_mem got %h exp a5", mem[8'h20]); end
      n_vec++; if (mem[8'h50] !== 8'h99) begin n_err++; $display("FAIL st_dbg_mem got %h exp 99", mem[8'h50]); end
      cyc();
      cpu_rd_req = 1'b0;
      n_vec++; if (cpu_rd_data !== 8'hA5) begin n_err++; $display("FAIL st_load got %h exp a5", cpu_rd_data); end
   endtask

   task automatic test_reset_mid_read();
      dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0010;
      cyc();
      n_vec++; if (dbg_ready !== 1'b1) begin n_err++; $display("FAIL mr_ready got %b exp 1", dbg_ready); end
      cyc();
      dbg_valid = 1'b0; reset = 1'b0;
      #1;
      n_vec++; if (dbg_rsp_data !== 8'h00) begin n_err++; $display("FAIL mr_rsp_data got %h exp 00", dbg_rsp_data); end
      cyc();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_vec++; if (dbg_rsp_valid !== 1'b0) begin n_err++; $display("FAIL mr_no_rsp_%0d got %b exp 0", i, dbg_rsp_valid); end
      end
      dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0070; dbg_wr_data = 8'h42;
      cyc();
      cpu_rd_req = 1'b1; cpu_addr = 16'h0020;
      #1;
      n_vec++; if (grant_dbg !== 1'b1) begin n_err++; $display("FAIL ar_grant_pre got %b exp 1", grant_dbg); end
      n_vec++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL ar_stall_pre got %b exp 1", cpu_stall); end
      reset = 1'b0;
      #1;
      n_vec++; if (grant_dbg !== 1'b0) begin n_err++; $display("FAIL ar_grant got %b exp 0", grant_dbg); end
      n_vec++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL ar_stall got %b exp 0", cpu_stall); end
      n_vec++; if (dmem_rd_addr !== 16'h0020) begin n_err++; $display("FAIL ar_rd_addr got %h exp 0020", dmem_rd_addr); end
      dbg_valid = 1'b0;
      cyc();
      reset = 1'b1; cpu_rd_req = 1'b0;
      cyc();
   endtask

   task automatic test_dbg_drop();
      dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0060; dbg_wr_data = 8'h55;
      cyc();
      dbg_valid = 1'b0;
      #1;
      n_vec++; if (grant_dbg !== 1'b1) begin n_err++; $display("FAIL drop_grant got %b exp 1", grant_dbg); end
      n_vec++; if (dmem_wr_en !== 1'b0) begin n_err++; $display("FAIL drop_wr_en got %b exp 0", dmem_wr_en); end
      n_vec++; if (dbg_ready !== 1'b0) begin n_err++; $display("FAIL drop_ready got %b exp 0", dbg_ready); end
      cyc();
      n_vec++; if (grant_dbg !== 1'b0) begin n_err++; $display("FAIL drop_grant_nxt got %b exp 0", grant_dbg); end
      n_vec++; if (mem[8'h60] !== 8'h00) begin n_err++; $display("FAIL drop_mem got %h exp 00", mem[8'h60]); end
      for (int i = 0; i < 2; i++) begin
         n_vec++; if (dbg_rsp_valid !== 1'b0) begin n_err++; $display("FAIL drop_rsp_%0d got %b exp 0", i, dbg_rsp_valid); end
         cyc();
      end
   endtask

   initial begin
      test_reset();
      test_dbg_rw();
      test_starve();
      test_cpu_store_stalled();
      test_reset_mid_read();
      test_dbg_drop();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
